dmem_arbiter: RTL and testbench

Two-requester arbiter for the data-side memory port (`raddr1`/`rdata1`/`wen`/`waddr`/`wdata`) of the unified memory. Requester 0 is the CPU load/store stage; requester 1 is the debug/program-loader port. The block selects one request per cycle and drives the memory port from the winner. It tracks in-flight reads so each read response is returned to the requester that issued it, and it bounds the loader's wait time under CPU pressure.

---
 rtl/dmem_arb_pkg.sv | 16 +
 rtl/dmem_arb_if.sv | 31 +++
 rtl/dmem_resp_pipe.sv | 30 +++
 rtl/dmem_arbiter.sv | 96 +++++++++
 tb/tb_dmem_arbiter.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Latency: n/a (types only).
// Backpressure: n/a.
package dmem_arb_pkg;
  localparam int PORT_CPU = 0;  // CPU load/store stage
  localparam int PORT_DBG = 1;  // debug / program loader
  localparam int AW       = 16; // byte address width
  localparam int WAW      = 15; // word address width
  localparam int DW       = 16; // data width

  // One entry of the read-response pipe: which requester owns the read.
  typedef struct packed {
    logic valid;
    logic id;
  } resp_tag_t;
endpackage

// File: rtl/dmem_arb_if.sv
// Bundle of requester, response and memory-port signals around the arbiter.
// Latency: n/a (wiring only).
// Backpressure: none; requesters hold a request until gnt and always accept rvalid.
// slave  = arbiter side, master = requesters + memory side.
interface dmem_arb_if;
  import dmem_arb_pkg::*;
  logic [1:0]     req;
  logic [AW-1:0]  addr0;
  logic [AW-1:0]  addr1;
  logic [1:0]     we;
  logic [DW-1:0]  wdata0;
  logic [DW-1:0]  wdata1;
  logic [1:0]     gnt;
  logic [1:0]     rvalid;
  logic [DW-1:0]  rdata;
  logic           cpu_stall;
  logic [WAW-1:0] m_raddr;
  logic [DW-1:0]  m_rdata;
  logic           m_wen;
  logic [WAW-1:0] m_waddr;
  logic [DW-1:0]  m_wdata;

  modport slave (
    input  req, addr0, addr1, we, wdata0, wdata1, m_rdata,
    output gnt, rvalid, rdata, cpu_stall, m_raddr, m_wen, m_waddr, m_wdata
  );
  modport master (
    output req, addr0, addr1, we, wdata0, wdata1, m_rdata,
    input  gnt, rvalid, rdata, cpu_stall, m_raddr, m_wen, m_waddr, m_wdata
  );
endinterface

// File: rtl/dmem_resp_pipe.sv
// Read-response tag pipe: carries {valid,id} alongside the memory read latency.
// Latency: RD_LAT cycles from tag_in to rvalid.
// Backpressure: none; shifts every cycle, async clear drops in-flight reads.
// Ports: clk, rst, tag_in (winner tag this cycle), rvalid[1:0] (one-hot or zero).
module dmem_resp_pipe
  import dmem_arb_pkg::*;
#(
  parameter int RD_LAT = 2
) (
  input  logic      clk,
  input  logic      rst,
  input  resp_tag_t tag_in,
  output logic [1:0] rvalid
);
  resp_tag_t stage [RD_LAT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RD_LAT; i++) stage[i] <= '0;
    end else begin
      stage[0] <= tag_in;
      for (int i = 1; i < RD_LAT; i++) stage[i] <= stage[i-1];
    end
  end

  always_comb begin
    rvalid = '0;
    if (stage[RD_LAT-1].valid) rvalid[stage[RD_LAT-1].id] = 1'b1;
  end
endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter (CPU, debug loader) for the unified memory's data port.
// Latency: grant and memory drive same cycle; read response RD_LAT cycles later.
// Backpressure: losing requester holds its request; responses cannot be stalled.
// Ports: clk, rst, bus (dmem_arb_if.slave: req/addr/we/wdata in, gnt/rvalid/rdata/
// cpu_stall out, m_* memory port). Build option DMEM_ARB_RR_EN selects round-robin
// in place of fixed CPU priority; the loader starvation override applies in both.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int RD_LAT   = 2,
  parameter int MAX_WAIT = 4
) (
  input logic        clk,
  input logic        rst,
  dmem_arb_if.slave  bus
);
  logic [3:0]     wait1;
  logic [1:0]     gnt_c;
  logic           win_vld;
  logic           win_id;
  logic           win_we;
  logic [WAW-1:0] win_word;
  logic [DW-1:0]  win_wdata;
  resp_tag_t      tag_in;
  logic           starve;

`ifdef DMEM_ARB_RR_EN
  logic ptr;  // preferred port when both request
`endif

  assign starve = bus.req[PORT_DBG] && (wait1 >= 4'(MAX_WAIT));

  always_comb begin
    gnt_c = '0;
    if (!rst) begin
      if (starve) begin
        gnt_c[PORT_DBG] = 1'b1;
      end else if (bus.req == 2'b11) begin
`ifdef DMEM_ARB_RR_EN
        gnt_c[ptr] = 1'b1;
`else
        gnt_c[PORT_CPU] = 1'b1;
`endif
      end else begin
        gnt_c = bus.req;
      end
    end
  end

  assign win_vld   = |gnt_c;
  assign win_id    = gnt_c[PORT_DBG];
  assign win_word  = win_id ? bus.addr1[AW-1:1] : bus.addr0[AW-1:1];
  assign win_we    = bus.we[win_id];
  assign win_wdata = win_id ? bus.wdata1 : bus.wdata0;

  assign bus.gnt       = gnt_c;
  assign bus.cpu_stall = !rst && bus.req[PORT_CPU] && !gnt_c[PORT_CPU];
  assign bus.m_wen     = win_vld && win_we;
  assign bus.m_raddr   = (win_vld && !win_we) ? win_word : '0;
  assign bus.m_waddr   = bus.m_wen ? win_word : '0;
  assign bus.m_wdata   = bus.m_wen ? win_wdata : '0;
  assign bus.rdata     = bus.m_rdata;

  assign tag_in.valid = win_vld && !win_we;
  assign tag_in.id    = win_id;

  // Loader starvation counter, saturating so a long stall cannot wrap to 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait1 <= '0;
    end else if (!bus.req[PORT_DBG] || gnt_c[PORT_DBG]) begin
      wait1 <= '0;
    end else if (wait1 != 4'hF) begin
      wait1 <= wait1 + 4'd1;
    end
  end

`ifdef DMEM_ARB_RR_EN
  // Pointer only moves on contended grants, so a lone requester never skews it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= 1'b0;
    end else if (bus.req == 2'b11 && win_vld) begin
      ptr <= ~ptr;
    end
  end
`else
`endif

  dmem_resp_pipe #(.RD_LAT(RD_LAT)) u_resp_pipe (
    .clk    (clk),
    .rst    (rst),
    .tag_in (tag_in),
    .rvalid (bus.rvalid)
  );
endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: reference arbitration model plus a
// response scoreboard fed at grant time and drained when rvalid is due.
// Inputs driven on the falling edge, outputs sampled 1 time unit later.
module tb_dmem_arbiter;
  localparam int RD_LAT   = 2;
  localparam int MAX_WAIT = 4;

  logic clk;
  logic rst;
  int   cyc;
  int   n_chk;
  int   n_fail;

  dmem_arb_if b ();

  dmem_arbiter #(.RD_LAT(RD_LAT), .MAX_WAIT(MAX_WAIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] pat(input int i);
    if (i == 8) return 16'hBEEF;
    return 16'(i * 257) ^ 16'h5A5A;
  endfunction

  // Memory behind the port: synchronous write, RD_LAT-cycle read.
  logic [15:0] mem   [256];
  logic [15:0] rpipe [4];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= pat(i);
      for (int i = 0; i < 4; i++) rpipe[i] <= '0;
    end else begin
      if (b.m_wen) mem[b.m_waddr[7:0]] <= b.m_wdata;
      rpipe[0] <= mem[b.m_raddr[7:0]];
      for (int i = 1; i < 4; i++) rpipe[i] <= rpipe[i-1];
    end
  end
  assign b.m_rdata = rpipe[RD_LAT-1];

  typedef struct {
    logic        id;
    logic [15:0] data;
    int          due;
  } exp_t;
  exp_t sb[$];

  logic [15:0] ref_mem [256];
  int          m_wait;
  logic        m_ptr;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_wait = 0;
    m_ptr  = 1'b0;
    sb.delete();
    for (int i = 0; i < 256; i++) ref_mem[i] = pat(i);
  endtask

  task automatic check_reset_outputs();
    chk("rst_gnt", b.gnt, 0);
    chk("rst_rvalid", b.rvalid, 0);
    chk("rst_stall", b.cpu_stall, 0);
    chk("rst_m_wen", b.m_wen, 0);
    chk("rst_m_raddr", b.m_raddr, 0);
    chk("rst_m_waddr", b.m_waddr, 0);
    chk("rst_m_wdata", b.m_wdata, 0);
    chk("rst_wait1", dut.wait1, 0);
  endtask

  // Reset held across two falling edges while both ports request reads.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    b.req = 2'b11; b.we = 2'b00;
    b.addr0 = 16'h0002; b.addr1 = 16'h0004;
    #1 check_reset_outputs();
    @(negedge clk);
    #1 check_reset_outputs();
    rst = 1'b0;
    b.req = 2'b00;
    model_reset();
  endtask

  task automatic step(input logic [1:0] r, input logic [1:0] w,
                      input logic [15:0] a0, input logic [15:0] a1,
                      input logic [15:0] d0, input logic [15:0] d1);
    logic [1:0]  eg;
    logic        id;
    logic [15:0] a;
    logic [15:0] d;
    exp_t        e;
    @(negedge clk);
    b.req = r; b.we = w; b.addr0 = a0; b.addr1 = a1; b.wdata0 = d0; b.wdata1 = d1;
    #1;
    eg = 2'b00;
    if (r[1] && m_wait >= MAX_WAIT) eg = 2'b10;
    else if (r == 2'b11) begin
`ifdef DMEM_ARB_RR_EN
      eg = m_ptr ? 2'b10 : 2'b01;
`else
      eg = 2'b01;
`endif
    end else eg = r;

    chk("gnt", b.gnt, eg);
    chk("cpu_stall", b.cpu_stall, r[0] & ~eg[0]);
    chk("wait1", dut.wait1, m_wait);
    if (eg != 2'b00) begin
      id = eg[1];
      a  = id ? a1 : a0;
      d  = id ? d1 : d0;
      if (w[id]) begin
        chk("m_wen", b.m_wen, 1);
        chk("m_waddr", b.m_waddr, a[15:1]);
        chk("m_wdata", b.m_wdata, d);
        ref_mem[a[8:1]] = d;
      end else begin
        chk("m_wen", b.m_wen, 0);
        chk("m_raddr", b.m_raddr, a[15:1]);
        e.id = id; e.data = ref_mem[a[8:1]]; e.due = cyc + RD_LAT;
        sb.push_back(e);
      end
    end else begin
      chk("idle_m_wen", b.m_wen, 0);
      chk("idle_m_raddr", b.m_raddr, 0);
    end

    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      chk("rvalid", b.rvalid, 32'(2'b01 << e.id));
      chk("rdata", b.rdata, e.data);
    end else begin
      chk("rvalid_idle", b.rvalid, 0);
    end

    if (!r[1] || eg[1]) m_wait = 0;
    else if (m_wait < 15) m_wait++;
`ifdef DMEM_ARB_RR_EN
    if (r == 2'b11 && eg != 2'b00) m_ptr = ~m_ptr;
`endif
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 16'h0);
  endtask

  initial begin
    cyc = 0; n_chk = 0; n_fail = 0;
    rst = 1'b1;
    b.req = '0; b.we = '0; b.addr0 = '0; b.addr1 = '0; b.wdata0 = '0; b.wdata1 = '0;
    model_reset();
    do_reset();

    // Lone CPU read of byte 0x0010 -> word 8 holds 0xBEEF.
    step(2'b01, 2'b00, 16'h0010, 16'h0, 16'h0, 16'h0);
    idle(RD_LAT + 1);

    // Both ports read continuously: priority plus starvation override.
    for (int i = 0; i < 15; i++)
      step(2'b11, 2'b00, 16'h0002, 16'h0004, 16'h0, 16'h0);
    idle(RD_LAT + 1);

    // Loader writes 0x1234 to 0x0020, CPU reads it back next cycle.
    step(2'b10, 2'b10, 16'h0, 16'h0020, 16'h0, 16'h1234);
    step(2'b01, 2'b00, 16'h0020, 16'h0, 16'h0, 16'h0);
    idle(RD_LAT + 1);

    // Interleaved reads 0,1,0 on consecutive cycles.
    step(2'b01, 2'b00, 16'h0006, 16'h0, 16'h0, 16'h0);
    step(2'b10, 2'b00, 16'h0, 16'h000A, 16'h0, 16'h0);
    step(2'b01, 2'b00, 16'h0010, 16'h0, 16'h0, 16'h0);
    idle(RD_LAT + 1);

    // Contended writes then reads of the written words.
    for (int i = 0; i < 6; i++)
      step(2'b11, 2'b11, 16'(16'h0040 + 2 * i), 16'(16'h0080 + 2 * i),
           16'(16'hA000 + i), 16'(16'hB000 + i));
    for (int i = 0; i < 6; i++)
      step(2'b11, 2'b00, 16'(16'h0040 + 2 * i), 16'(16'h0080 + 2 * i), 16'h0, 16'h0);
    idle(RD_LAT + 1);
    chk("sb_drain", sb.size(), 0);

    // Two reads granted, then reset: those responses must never surface.
    step(2'b01, 2'b00, 16'h0012, 16'h0, 16'h0, 16'h0);
    step(2'b10, 2'b00, 16'h0, 16'h0014, 16'h0, 16'h0);
    do_reset();
    idle(RD_LAT + 3);
    chk("sb_final", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
